// File: rtl/pulse_debouncer.sv
// Two-flop synchroniser plus 4-state debounce FSM for a bouncy event input.
// Emits single-cycle rise/fall pulses, the debounced level and a glitch tally.
module pulse_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5,
   parameter int GLITCH_W        = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                btn_in,
   output logic                pulse,
   output logic                fall,
   output logic                level,
   output logic                busy,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   typedef enum logic [1:0] {
      LOW,
      RISE_CHK,
      HIGH,
      FALL_CHK
   } state_t;

   localparam logic [CNT_W-1:0]    LP_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]    LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [GLITCH_W-1:0] LP_G1   = GLITCH_W'(1);
   localparam logic [GLITCH_W-1:0] LP_GMAX = '1;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_s1;
   logic                r_s2;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic                r_pulse;
   logic                w_pulse_nxt;
   logic                r_fall;
   logic                w_fall_nxt;
   logic                r_level;
   logic                w_level_nxt;
   logic [GLITCH_W-1:0] r_glitch;
   logic [GLITCH_W-1:0] w_glitch_nxt;
   logic [GLITCH_W-1:0] w_glitch_sat;

   // Saturating increment: the tally sticks at all-ones instead of wrapping.
   assign w_glitch_sat = (r_glitch == LP_GMAX) ? r_glitch : r_glitch + LP_G1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_state  <= LOW;
         r_cnt    <= '0;
         r_pulse  <= 1'b0;
         r_fall   <= 1'b0;
         r_level  <= 1'b0;
         r_glitch <= '0;
      end else begin
         r_s1     <= btn_in;
         r_s2     <= r_s1;
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_pulse  <= w_pulse_nxt;
         r_fall   <= w_fall_nxt;
         r_level  <= w_level_nxt;
         r_glitch <= w_glitch_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_pulse_nxt  = 1'b0;
      w_fall_nxt   = 1'b0;
      w_level_nxt  = r_level;
      w_glitch_nxt = r_glitch;
      unique case (r_state)
         LOW: begin
            if (r_s2) begin
               w_state_nxt = RISE_CHK;
               w_cnt_nxt   = LP_ONE;
            end
         end
         RISE_CHK: begin
            if (!r_s2) begin
               w_state_nxt  = LOW;
               w_cnt_nxt    = '0;
               w_glitch_nxt = w_glitch_sat;
            end else if (r_cnt == LP_LAST) begin
               w_state_nxt = HIGH;
               w_cnt_nxt   = '0;
               w_level_nxt = 1'b1;
               w_pulse_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + LP_ONE;
            end
         end
         HIGH: begin
            if (!r_s2) begin
               w_state_nxt = FALL_CHK;
               w_cnt_nxt   = LP_ONE;
            end
         end
         FALL_CHK: begin
            if (r_s2) begin
               w_state_nxt  = HIGH;
               w_cnt_nxt    = '0;
               w_glitch_nxt = w_glitch_sat;
            end else if (r_cnt == LP_LAST) begin
               w_state_nxt = LOW;
               w_cnt_nxt   = '0;
               w_level_nxt = 1'b0;
               w_fall_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + LP_ONE;
            end
         end
         default: begin
            w_state_nxt = LOW;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign pulse      = r_pulse;
   assign fall       = r_fall;
   assign level      = r_level;
   assign busy       = (r_state == RISE_CHK) || (r_state == FALL_CHK);
   assign glitch_cnt = r_glitch;

endmodule

// File: tb/tb_pulse_debouncer.sv
// Bench for pulse_debouncer: vector table, directed corner sequences and
// random runs compared with a run-length reference model.
module tb_pulse_debouncer;

   localparam int DC = 4;

   logic       clk;
   logic       rst_n;
   logic       btn;
   logic       pulse;
   logic       fall;
   logic       level;
   logic       busy;
   logic [7:0] gcnt;
   logic       pulse2;
   logic       fall2;
   logic       level2;
   logic       busy2;
   logic [1:0] gcnt2;

   int n_chk;
   int n_fail;

   pulse_debouncer #(
      .DEBOUNCE_CYCLES(DC),
      .CNT_W(5),
      .GLITCH_W(8)
   ) dut (
      .clk(clk),
      .reset(rst_n),
      .btn_in(btn),
      .pulse(pulse),
      .fall(fall),
      .level(level),
      .busy(busy),
      .glitch_cnt(gcnt)
   );

   pulse_debouncer #(
      .DEBOUNCE_CYCLES(DC),
      .CNT_W(5),
      .GLITCH_W(2)
   ) dut2 (
      .clk(clk),
      .reset(rst_n),
      .btn_in(btn),
      .pulse(pulse2),
      .fall(fall2),
      .level(level2),
      .busy(busy2),
      .glitch_cnt(gcnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a transition is accepted after DC consecutive
   // synchronised samples that differ from the debounced level.
   bit m_q[$];
   int m_run;
   bit m_level;
   bit m_pulse;
   bit m_fall;
   int m_glitch;

   function automatic void chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int sat(int v, int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic void model_step(bit b, bit r);
      bit s;
      if (!r) begin
         m_q.delete();
         m_q.push_back(1'b0);
         m_q.push_back(1'b0);
         m_run    = 0;
         m_level  = 1'b0;
         m_pulse  = 1'b0;
         m_fall   = 1'b0;
         m_glitch = 0;
      end else begin
         s = m_q.pop_front();
         m_q.push_back(b);
         m_pulse = 1'b0;
         m_fall  = 1'b0;
         if (s != m_level) begin
            m_run++;
            if (m_run == DC) begin
               m_level = s;
               m_pulse = s;
               m_fall  = !s;
               m_run   = 0;
            end
         end else begin
            if (m_run > 0) m_glitch++;
            m_run = 0;
         end
      end
   endfunction

   task automatic cycle(input bit b, input bit r);
      btn   = b;
      rst_n = r;
      @(posedge clk);
      model_step(b, r);
      @(negedge clk);
      chk("m_pulse", int'(pulse), int'(m_pulse));
      chk("m_fall", int'(fall), int'(m_fall));
      chk("m_level", int'(level), int'(m_level));
      chk("m_busy", int'(busy), int'(m_run > 0));
      chk("m_glitch", int'(gcnt), sat(m_glitch, 255));
      chk("m_glitch2", int'(gcnt2), sat(m_glitch, 3));
      chk("excl", int'(pulse && fall), 0);
   endtask

   typedef struct {
      bit   b;
      bit   r;
      bit   p;
      bit   f;
      bit   l;
      bit   bs;
      int   g;
   } vec_t;

   vec_t vt[$];

   initial begin
      vec_t v;
      int   g;
      int   gexp[5];
      int   npulse;
      int   bin;
      int   nterm;
      bit   b;
      bit   rr;
      int   len;

      n_chk  = 0;
      n_fail = 0;
      btn    = 1'b0;
      rst_n  = 1'b0;

      // Rise at edge 0, fall at edge 20, then three 2-high/2-low glitches.
      for (int e = 0; e < 50; e++) begin
         g    = e - 30;
         v.b  = (e < 20) || (e >= 30 && e < 42 && (g % 4) < 2);
         v.r  = 1'b1;
         v.p  = (e == 5);
         v.f  = (e == 25);
         v.l  = (e >= 5 && e < 25);
         v.bs = (e >= 2 && e <= 4) || (e >= 22 && e <= 24) ||
                (e >= 30 && e < 42 && (g % 4) >= 2);
         v.g  = (g >= 4 ? 1 : 0) + (g >= 8 ? 1 : 0) + (g >= 12 ? 1 : 0);
         vt.push_back(v);
      end

      @(negedge clk);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
      chk("rst_pulse", int'(pulse), 0);
      chk("rst_fall", int'(fall), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_glitch", int'(gcnt), 0);

      foreach (vt[i]) begin
         cycle(vt[i].b, vt[i].r);
         chk("v_pulse", int'(pulse), int'(vt[i].p));
         chk("v_fall", int'(fall), int'(vt[i].f));
         chk("v_level", int'(level), int'(vt[i].l));
         chk("v_busy", int'(busy), int'(vt[i].bs));
         chk("v_glitch", int'(gcnt), vt[i].g);
         chk("v_glitch2", int'(gcnt2), vt[i].g);
      end

      // Narrow GLITCH_W saturates at 3.
      gexp = '{1, 2, 3, 3, 3};
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, 1'b1);
         for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
         chk("sat_glitch2", int'(gcnt2), gexp[k]);
         chk("sat_glitch8", int'(gcnt), k + 1);
         chk("sat_level", int'(level), 0);
      end

      // Reset lands mid-qualification while the input stays high.
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
      for (int e = 0; e < 3; e++) begin
         cycle(1'b1, 1'b1);
         chk("mid_prepulse", int'(pulse), 0);
      end
      chk("mid_busy", int'(busy), 1);
      cycle(1'b1, 1'b0);
      chk("mid_rst_pulse", int'(pulse), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_level", int'(level), 0);
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b1, 1'b1);
         chk("mid_post_pulse", int'(pulse), int'(i == 6));
         chk("mid_post_fall", int'(fall), 0);
      end
      chk("mid_level", int'(level), 1);

      // Toggling every cycle never qualifies.
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
      npulse = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(((i % 2) == 0), 1'b1);
         npulse += int'(pulse);
      end
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1);
         npulse += int'(pulse);
      end
      chk("tog_pulses", npulse, 0);
      chk("tog_glitch", int'(gcnt), 10);
      chk("tog_glitch2", int'(gcnt2), 3);
      chk("tog_level", int'(level), 0);

      // Eight clean presses into a 3-bit Gray counter.
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
      npulse = 0;
      bin    = 0;
      nterm  = 0;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 24; i++) begin
            cycle((i < 12), 1'b1);
            if (pulse) begin
               npulse++;
               if (bin == 7) nterm++;
               bin = (bin + 1) % 8;
            end
         end
      end
      chk("gray_pulses", npulse, 8);
      chk("gray_state", bin ^ (bin >> 1), 0);
      chk("gray_term", nterm, 1);

      // Random bursts with occasional resets.
      for (int k = 0; k < 1500; k++) begin
         b   = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 7));
         for (int i = 0; i < len; i++) begin
            rr = ($urandom_range(0, 199) != 0);
            cycle(b, rr);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
